// File: rtl/lc3b_types.sv
// lc3b_types: shared types and constants for the LC-3b pipeline.
//   pipe_vec_t : per-stage bit vector sized for the deepest legal pipe (8 stages)
//   STAGE_*    : stage positions of the default 5-stage configuration
//   MAX_STAGES / MIN_STAGES : legal range of the pipeline depth
package lc3b_types;

    localparam int MIN_STAGES = 3;
    localparam int MAX_STAGES = 8;

    typedef logic [MAX_STAGES-1:0] pipe_vec_t;

    localparam int STAGE_IF  = 0;
    localparam int STAGE_ID  = 1;
    localparam int STAGE_EX  = 2;
    localparam int STAGE_MEM = 3;
    localparam int STAGE_WB  = 4;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter used for pipeline performance statistics.
//   clk   : clock
//   reset : asynchronous active-low reset, clears the count
//   clr   : synchronous clear, wins over inc
//   inc   : count enable for this cycle
//   out   : current count; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] out
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall / bubble / flush sequencing for the LC-3b pipeline.
//   Inputs : clk, reset (async active-low), imem_resp, dmem_req, dmem_resp,
//            hazard (load-use at HAZARD_STAGE), redirect (at REDIRECT_STAGE),
//            perf_clr (synchronous counter clear)
//   Outputs: imem_read, dmem_go, pc_load, stage_load/stage_zero (bit i = the
//            register feeding stage i; bit 0 unused), valid (per-stage valid
//            bits, the only state of this block), flush, six saturating
//            performance counters
//
// Cache handshake: a request strobe (imem_read / dmem_go) stays high while the
// pipe is frozen on it; the cycle in which the matching *_resp is high is the
// cycle the transfer completes and the pipe may advance. The datapath holds
// its inputs stable while frozen, so redirect/hazard are simply re-evaluated.
module pipe_ctrl
    import lc3b_types::*;
#(
    parameter int STAGES         = STAGE_WB + 1,
    parameter int HAZARD_STAGE   = STAGE_ID,
    parameter int MEM_STAGE      = STAGE_MEM,
    parameter int REDIRECT_STAGE = STAGE_WB,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_resp,
    output logic              imem_read,
    input  logic              dmem_req,
    input  logic              dmem_resp,
    output logic              dmem_go,
    input  logic              hazard,
    input  logic              redirect,
    input  logic              perf_clr,
    output logic              pc_load,
    output logic [STAGES-1:0] stage_load,
    output logic [STAGES-1:0] stage_zero,
    output logic [STAGES-1:0] valid,
    output logic              flush,
    output logic [CNT_W-1:0]  cnt_cycles,
    output logic [CNT_W-1:0]  cnt_retired,
    output logic [CNT_W-1:0]  cnt_istall,
    output logic [CNT_W-1:0]  cnt_dstall,
    output logic [CNT_W-1:0]  cnt_hazard,
    output logic [CNT_W-1:0]  cnt_flush
);

    if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("pipe_ctrl: STAGES must be in 3..8");
    end
    if (!(HAZARD_STAGE >= 1 && HAZARD_STAGE < MEM_STAGE &&
          MEM_STAGE <= REDIRECT_STAGE && REDIRECT_STAGE <= STAGES - 1)) begin : g_bad_order
        $error("pipe_ctrl: need 1 <= HAZARD_STAGE < MEM_STAGE <= REDIRECT_STAGE <= STAGES-1");
    end

    localparam logic [STAGES-1:0] VALID_RST = STAGES'(1);

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] w_valid_nxt;
    logic              w_istall;
    logic              w_dstall;
    logic              w_go;
    logic              w_redir_acc;
    logic              w_haz_acc;

    // A D-cache stall drops the fetch strobe so a frozen fetch is not re-issued;
    // that also makes istall and dstall mutually exclusive.
    assign dmem_go     = dmem_req & r_valid[MEM_STAGE];
    assign w_dstall    = dmem_go & ~dmem_resp;
    assign imem_read   = reset & ~w_dstall;
    assign w_istall    = imem_read & ~imem_resp;
    assign w_go        = ~w_istall & ~w_dstall;

    // Events are only honoured for real instructions; a bubble never acts.
    assign w_redir_acc = w_go & redirect & r_valid[REDIRECT_STAGE];
    assign w_haz_acc   = w_go & hazard & r_valid[HAZARD_STAGE] & ~w_redir_acc;
    assign flush       = w_redir_acc;

    always_comb begin
        pc_load     = 1'b0;
        stage_load  = '0;
        stage_zero  = '0;
        w_valid_nxt = r_valid;
        if (w_go) begin
            pc_load        = 1'b1;
            w_valid_nxt[0] = 1'b1;
            for (int i = 1; i < STAGES; i++) begin
                stage_load[i]  = 1'b1;
                w_valid_nxt[i] = r_valid[i-1];
            end
            if (w_redir_acc) begin
                // Squash everything younger than the redirecting instruction;
                // it moves on (or retires) through the normal-load stages.
                for (int i = 1; i <= REDIRECT_STAGE; i++) begin
                    stage_load[i]  = 1'b0;
                    stage_zero[i]  = 1'b1;
                    w_valid_nxt[i] = 1'b0;
                end
            end else if (w_haz_acc) begin
                // Hold the consumer and everything behind it, feed a bubble
                // into the stage right after it.
                pc_load = 1'b0;
                for (int i = 1; i <= HAZARD_STAGE; i++) begin
                    stage_load[i]  = 1'b0;
                    w_valid_nxt[i] = r_valid[i];
                end
                stage_load[HAZARD_STAGE+1]  = 1'b0;
                stage_zero[HAZARD_STAGE+1]  = 1'b1;
                w_valid_nxt[HAZARD_STAGE+1] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= VALID_RST;
        end else begin
            r_valid <= w_valid_nxt;
        end
    end

    assign valid = r_valid;

    sat_counter #(.CNT_W(CNT_W)) u_cnt_cycles (
        .clk(clk), .reset(reset), .clr(perf_clr), .inc(1'b1), .out(cnt_cycles)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt_retired (
        .clk(clk), .reset(reset), .clr(perf_clr), .inc(w_go & r_valid[STAGES-1]), .out(cnt_retired)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt_istall (
        .clk(clk), .reset(reset), .clr(perf_clr), .inc(w_istall & ~w_dstall), .out(cnt_istall)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt_dstall (
        .clk(clk), .reset(reset), .clr(perf_clr), .inc(w_dstall), .out(cnt_dstall)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt_hazard (
        .clk(clk), .reset(reset), .clr(perf_clr), .inc(w_haz_acc), .out(cnt_hazard)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
        .clk(clk), .reset(reset), .clr(perf_clr), .inc(w_redir_acc), .out(cnt_flush)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl (default 5-stage config with
// 32-bit counters, plus a 4-bit-counter copy sharing the same inputs for the
// saturation check). Inputs change on the falling edge; outputs are sampled
// 1 ns later, so registered values reflect the preceding rising edge.
module tb_pipe_ctrl;

    localparam int S = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic imem_resp, dmem_req, dmem_resp, hazard, redirect, perf_clr;

    logic          imem_read, dmem_go, pc_load, flush;
    logic [S-1:0]  stage_load, stage_zero, valid;
    logic [31:0]   cnt_cycles, cnt_retired, cnt_istall, cnt_dstall, cnt_hazard, cnt_flush;

    logic          s_imem_read, s_dmem_go, s_pc_load, s_flush;
    logic [S-1:0]  s_stage_load, s_stage_zero, s_valid;
    logic [3:0]    s_cycles, s_retired, s_istall, s_dstall, s_hazard, s_flushc;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(rst_n), .imem_resp(imem_resp), .imem_read(imem_read),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp), .dmem_go(dmem_go),
        .hazard(hazard), .redirect(redirect), .perf_clr(perf_clr),
        .pc_load(pc_load), .stage_load(stage_load), .stage_zero(stage_zero),
        .valid(valid), .flush(flush),
        .cnt_cycles(cnt_cycles), .cnt_retired(cnt_retired), .cnt_istall(cnt_istall),
        .cnt_dstall(cnt_dstall), .cnt_hazard(cnt_hazard), .cnt_flush(cnt_flush)
    );

    pipe_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(rst_n), .imem_resp(imem_resp), .imem_read(s_imem_read),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp), .dmem_go(s_dmem_go),
        .hazard(hazard), .redirect(redirect), .perf_clr(perf_clr),
        .pc_load(s_pc_load), .stage_load(s_stage_load), .stage_zero(s_stage_zero),
        .valid(s_valid), .flush(s_flush),
        .cnt_cycles(s_cycles), .cnt_retired(s_retired), .cnt_istall(s_istall),
        .cnt_dstall(s_dstall), .cnt_hazard(s_hazard), .cnt_flush(s_flushc)
    );

    // Scoreboard: expectations are queued as each step is driven and popped
    // in the same order when the step's outputs are sampled.
    task automatic push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
        hazard = 1'b0; redirect = 1'b0; perf_clr = 1'b0;

        // ---- reset state
        tick(); tick();
        push(32'h01); push(0); push(0); push(0); push(0); push(0);
        settle();
        chk("rst_valid", 32'(valid));
        chk("rst_cycles", cnt_cycles);
        chk("rst_retired", cnt_retired);
        chk("rst_flush", 32'(flush));
        chk("rst_imem_read", 32'(imem_read));
        chk("rst_s_cycles", 32'(s_cycles));
        rst_n = 1'b1;

        // ---- test 1: fill
        for (int k = 1; k <= 5; k++) begin
            tick();
            push(32'((1 << ((k + 1 > S) ? S : k + 1)) - 1)); push(1); push(32'h1E);
            settle();
            chk("fill_valid", 32'(valid));
            chk("fill_pc_load", 32'(pc_load));
            chk("fill_stage_load", 32'(stage_load));
        end
        push(1); push(5);
        chk("fill_retired", cnt_retired);
        chk("fill_cycles", cnt_cycles);

        // ---- test 2: D-cache stall for 3 cycles
        tick();
        dmem_req = 1'b1; dmem_resp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            push(0); push(0); push(0); push(1);
            settle();
            chk("dst_imem_read", 32'(imem_read));
            chk("dst_pc_load", 32'(pc_load));
            chk("dst_stage_load", 32'(stage_load));
            chk("dst_dmem_go", 32'(dmem_go));
        end
        tick();
        dmem_resp = 1'b1;
        push(1); push(32'h1E); push(1); push(3); push(2);
        settle();
        chk("dresp_pc_load", 32'(pc_load));
        chk("dresp_stage_load", 32'(stage_load));
        chk("dresp_imem_read", 32'(imem_read));
        chk("dresp_cnt_dstall", cnt_dstall);
        chk("dresp_retired", cnt_retired);
        tick();
        dmem_req = 1'b0; dmem_resp = 1'b0;
        push(3); push(3); push(32'h1F); push(10);
        settle();
        chk("post_d_retired", cnt_retired);
        chk("post_d_dstall", cnt_dstall);
        chk("post_d_valid", 32'(valid));
        chk("post_d_cycles", cnt_cycles);

        // ---- test 3: one-cycle load-use hazard
        tick();
        hazard = 1'b1;
        push(0); push(32'h18); push(32'h04); push(0);
        settle();
        chk("haz_pc_load", 32'(pc_load));
        chk("haz_stage_load", 32'(stage_load));
        chk("haz_stage_zero", 32'(stage_zero));
        chk("haz_flush", 32'(flush));
        tick();
        hazard = 1'b0;
        push(32'h1B); push(1);
        settle();
        chk("haz_bubble_valid", 32'(valid));
        chk("haz_cnt", cnt_hazard);
        tick(); push(32'h17); settle(); chk("haz_drain1", 32'(valid));
        tick(); push(32'h0F); settle(); chk("haz_drain2", 32'(valid));

        // ---- test 4: redirect beats hazard
        tick();
        redirect = 1'b1; hazard = 1'b1;
        push(32'h1F); push(1); push(32'h1E); push(0); push(1);
        settle();
        chk("rd_valid_pre", 32'(valid));
        chk("rd_flush", 32'(flush));
        chk("rd_stage_zero", 32'(stage_zero));
        chk("rd_stage_load", 32'(stage_load));
        chk("rd_pc_load", 32'(pc_load));
        tick();
        redirect = 1'b0; hazard = 1'b0;
        push(32'h01); push(1); push(1);
        settle();
        chk("rd_valid_post", 32'(valid));
        chk("rd_cnt_flush", cnt_flush);
        chk("rd_cnt_hazard", cnt_hazard);
        for (int k = 0; k < 4; k++) begin
            tick();
            push(32'((1 << (k + 2)) - 1));
            settle();
            chk("refill_valid", 32'(valid));
        end

        // ---- test 5: redirect deferred behind an I-cache stall
        tick();
        redirect = 1'b1; imem_resp = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) tick();
            push(0); push(0); push(0); push(1);
            settle();
            chk("ist_flush", 32'(flush));
            chk("ist_pc_load", 32'(pc_load));
            chk("ist_stage_load", 32'(stage_load));
            chk("ist_imem_read", 32'(imem_read));
        end
        tick();
        imem_resp = 1'b1;
        push(1); push(2);
        settle();
        chk("ist_flush_go", 32'(flush));
        chk("ist_cnt_istall", cnt_istall);
        tick();
        push(0); push(32'h01); push(2);
        settle();
        chk("ist_flush_once", 32'(flush));
        chk("ist_valid_post", 32'(valid));
        chk("ist_cnt_flush", cnt_flush);

        // ---- reset asserted in the middle of an I-cache stall
        tick();
        redirect = 1'b0; imem_resp = 1'b0;
        rst_n = 1'b0;
        push(32'h01); push(0); push(0); push(0);
        settle();
        chk("mid_rst_valid", 32'(valid));
        chk("mid_rst_cycles", cnt_cycles);
        chk("mid_rst_flush_cnt", cnt_flush);
        chk("mid_rst_istall_cnt", cnt_istall);

        // ---- test 6: 4-bit counter saturation and perf_clr
        tick();
        rst_n = 1'b1; imem_resp = 1'b1;
        repeat (20) tick();
        push(20); push(15); push(32'h1F);
        settle();
        chk("sat_main_cycles", cnt_cycles);
        chk("sat_s_cycles", 32'(s_cycles));
        chk("sat_valid", 32'(valid));
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        push(0); push(0);
        settle();
        chk("clr_main_cycles", cnt_cycles);
        chk("clr_s_cycles", 32'(s_cycles));
        tick();
        push(1); push(1);
        settle();
        chk("clr_main_next", cnt_cycles);
        chk("clr_s_next", 32'(s_cycles));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline sequencing unit for the LC-3b pipeline. It centralises the stall, bubble and flush decisions that the datapath currently makes inline.
- Inputs: I-cache and D-cache handshakes, load-use hazard, control-flow redirect.
- Outputs: per-stage register load/clear enables, per-stage valid bits, performance counters.
- Generalises the fixed 5-stage control to STAGES stages, with configurable hazard, memory and redirect stage positions.

Parameters:
STAGES, 5, number of pipeline stages; stage 0 = IF, STAGES-1 = WB; legal range 3..8
HAZARD_STAGE, 1, stage holding the consumer on a load-use hazard; bubble is inserted after it
MEM_STAGE, 3, stage issuing D-cache requests
REDIRECT_STAGE, 4, stage where redirects resolve; the redirecting instruction itself completes
CNT_W, 32, performance counter width

Legal ordering: 1 <= HAZARD_STAGE < MEM_STAGE <= REDIRECT_STAGE <= STAGES-1.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
imem_resp  in  1  I-cache response
imem_read  out  1  I-cache read strobe
dmem_req  in  1  stage MEM_STAGE holds a load/store (raw decode)
dmem_resp  in  1  D-cache response
dmem_go  out  1  qualified D-cache strobe = dmem_req & valid[MEM_STAGE]
hazard  in  1  load-use hazard detected at HAZARD_STAGE
redirect  in  1  taken branch/jump/trap resolved at REDIRECT_STAGE
perf_clr  in  1  synchronous clear of all counters
pc_load  out  1  PC register enable
stage_load  out  STAGES  bit i = load the register feeding stage i (bit 0 unused, tied 0)
stage_zero  out  STAGES  bit i = clear the register feeding stage i to a bubble (bit 0 unused)
valid  out  STAGES  per-stage valid bits
flush  out  1  redirect accepted this cycle
cnt_cycles, cnt_retired, cnt_istall, cnt_dstall, cnt_hazard, cnt_flush  out  CNT_W each  saturating counters

Behaviour:
- Reset (reset=0, async):
  - valid = 0 except valid[0] = 1.
  - All counters = 0; flush = 0.
  - Combinational outputs follow from the reset state.
- Stall terms:
  - imem_read = reset & ~dstall.
  - istall = imem_read & ~imem_resp.
  - dstall = dmem_go & ~dmem_resp.
  - go = ~istall & ~dstall.
- Memory stall (go=0): whole pipe frozen. pc_load = 0, stage_load = 0, stage_zero = 0, valid holds, redirect and hazard deferred. Inputs are held stable by the frozen pipe.
- Priority when go=1: redirect > hazard > normal advance.
- Redirect accepted iff go & redirect & valid[REDIRECT_STAGE]:
  - flush = 1, pc_load = 1.
  - stage_zero[1..REDIRECT_STAGE] = 1; next valid[1..REDIRECT_STAGE] = 0.
  - Stages above REDIRECT_STAGE load normally. The redirecting instruction advances to REDIRECT_STAGE+1, or retires if REDIRECT_STAGE = STAGES-1.
  - A hazard in the same cycle is ignored.
- Hazard accepted iff go & hazard & valid[HAZARD_STAGE] & no accepted redirect:
  - pc_load = 0; stage_load[1..HAZARD_STAGE] = 0 (hold).
  - stage_zero[HAZARD_STAGE+1] = 1; next valid[HAZARD_STAGE+1] = 0.
  - Stages above HAZARD_STAGE+1 load.
  - Consecutive hazard cycles each insert one bubble.
- Normal advance: pc_load = 1, all stage_load = 1, next valid[i] = valid[i-1], valid[0] stays 1.
- Hazard or redirect with the named stage invalid: ignored. A bubble never stalls or flushes.
- stage_load and stage_zero are never both 1 for the same bit; zero wins.
- Counters update on clock edges, saturate at all-ones, and never wrap. perf_clr takes precedence over increments.
  - cnt_cycles: +1 every cycle.
  - cnt_retired: +1 when go & valid[STAGES-1].
  - cnt_istall: +1 when istall.
  - cnt_dstall: +1 when dstall; if both stalls are present, only cnt_dstall counts.
  - cnt_hazard: +1 per accepted hazard.
  - cnt_flush: +1 per accepted redirect.
- Reset asserted mid-stall or mid-flush: immediate return to the reset state; no partial update.

Decomposition:
- lc3b_types additions:
  - typedef pipe_vec_t = logic [7:0] (max stages);
  - constants STAGE_IF = 0, STAGE_ID = 1, STAGE_EX = 2, STAGE_MEM = 3, STAGE_WB = 4 for the default config.
- Sub-module sat_counter (parameter CNT_W; ports clk, reset, clr, inc, out), instantiated six times.
- Parameter legality is checked with elaboration-time assertions.

Test Plan:
1. Reset release, imem_resp=1 every cycle, no other events -> valid fills 00001, 00011, ... 11111 by cycle 4; cnt_retired = 1 on cycle 5; pc_load = 1 throughout.
2. Pipe full, dmem_req=1 with dmem_resp delayed 3 cycles -> imem_read = 0, pc_load = 0, stage_load = 0 for 3 cycles; cnt_dstall = 3; normal advance on the response cycle.
3. hazard=1 for one cycle with valid[1] = 1 -> pc_load = 0, stage_load[1] = 0, stage_zero[2] = 1; next cycle valid[2] = 0; cnt_hazard = 1.
4. redirect=1 and hazard=1 in the same cycle, valid = 11111 -> flush = 1, stage_zero = 11110, next valid = 00001; cnt_flush = 1, cnt_hazard = 0.
5. redirect=1 while istall is active for 2 cycles -> no flush until imem_resp; flush then asserts exactly one cycle.
6. CNT_W = 4, run 20 cycles -> cnt_cycles saturates at 15; a perf_clr pulse gives 0 on the next cycle.
